// File: rtl/run_sequencer.sv
// run_sequencer: run controller for start, PC advance, load stalls, halt and watchdog
module run_sequencer #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W = 16,
   parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFFF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Ack,
   input  logic             LoadInst,
   output logic             PCInit,
   output logic             PCEn,
   output logic             RegWrGate,
   output logic             MemWrGate,
   output logic             Done,
   output logic             Timeout,
   output logic [CNT_W-1:0] CycleCount
);
   typedef enum logic [2:0] {s_idle, s_armed, s_run, s_load_wait, s_halt} state_t;
   localparam logic [CNT_W-1:0] wd_lim = MAX_CYCLES - CNT_W'(1);
   state_t state, nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0] stall;
   logic to_q, set_to, wd, counting;
   assign wd = (MAX_CYCLES != '0) && (cnt == wd_lim);
   assign counting = (state == s_run) || (state == s_load_wait);
   assign Done = state == s_halt;
   assign Timeout = to_q;
   assign CycleCount = cnt;
   // next state and strobes; RUN gating follows Start/Ack/LoadInst combinationally
   always_comb begin
      nxt = state;
      PCInit = 1'b0;
      PCEn = 1'b0;
      RegWrGate = 1'b0;
      MemWrGate = 1'b0;
      set_to = 1'b0;
      case (state)
         s_idle: nxt = Start ? s_armed : s_idle;
         s_armed: begin
            PCInit = 1'b1;
            nxt = Start ? s_armed : s_run;
         end
         s_run:
            if (Start) nxt = s_armed;
            else if (Ack) nxt = s_halt;
            else if (wd) begin
               nxt = s_halt;
               set_to = 1'b1;
            end else if (LoadInst && LOAD_LAT > 0) nxt = s_load_wait;
            else begin
               PCEn = 1'b1;
               RegWrGate = 1'b1;
               MemWrGate = 1'b1;
            end
         s_load_wait:
            if (Start) nxt = s_armed;
            else if (wd) begin
               nxt = s_halt;
               set_to = 1'b1;
            end else if (stall == 3'd1) begin
               PCEn = 1'b1;
               RegWrGate = 1'b1;
               nxt = s_run;
            end
         s_halt: nxt = Start ? s_armed : s_halt;
         default: nxt = s_idle;
      endcase
   end
   // state, saturating run counter, stall counter and timeout flag
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= s_idle;
         cnt <= '0;
         stall <= '0;
         to_q <= 1'b0;
      end else begin
         state <= nxt;
         if (nxt == s_armed) begin
            cnt <= '0;
            to_q <= 1'b0;
         end else begin
            if (counting && !(&cnt)) cnt <= cnt + CNT_W'(1);
            if (set_to) to_q <= 1'b1;
         end
         if (state == s_run && nxt == s_load_wait) stall <= 3'(LOAD_LAT);
         else if (state == s_load_wait) stall <= stall - 3'd1;
      end
   end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench for run_sequencer with stall and no-stall instances
module tb_run_sequencer;
   typedef struct {
      string tag;
      logic [5:0] v;
      logic [15:0] c;
      bit k1;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic ack = 1'b0;
   logic ld = 1'b0;
   logic pi0, pe0, rw0, mw0, d0, t0;
   logic pi1, pe1, rw1, mw1, d1, t1;
   logic [15:0] c0, c1;
   exp_t q[$];
   int total = 0;
   int bad = 0;
   run_sequencer #(.LOAD_LAT(2), .CNT_W(16), .MAX_CYCLES(16'd8)) u0 (
      .Clk(clk), .Reset(rst), .Start(start), .Ack(ack), .LoadInst(ld),
      .PCInit(pi0), .PCEn(pe0), .RegWrGate(rw0), .MemWrGate(mw0),
      .Done(d0), .Timeout(t0), .CycleCount(c0)
   );
   run_sequencer #(.LOAD_LAT(0), .CNT_W(16), .MAX_CYCLES(16'hFFFF)) u1 (
      .Clk(clk), .Reset(rst), .Start(start), .Ack(ack), .LoadInst(ld),
      .PCInit(pi1), .PCEn(pe1), .RegWrGate(rw1), .MemWrGate(mw1),
      .Done(d1), .Timeout(t1), .CycleCount(c1)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask
   task automatic step(input string tag, input logic r, input logic s, input logic a,
                       input logic l, input logic [5:0] v, input logic [15:0] c, input bit k1);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      start = s;
      ack = a;
      ld = l;
      e.tag = tag;
      e.v = v;
      e.c = c;
      e.k1 = k1;
      q.push_back(e);
   endtask
   // pop one expectation per cycle and compare mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check({e.tag, ".out"}, {26'd0, pi0, pe0, rw0, mw0, d0, t0}, {26'd0, e.v});
         check({e.tag, ".cnt"}, {16'd0, c0}, {16'd0, e.c});
         check({e.tag, ".excl"}, {31'd0, pi0 & pe0}, 32'd0);
         if (e.k1) begin
            check({e.tag, ".nostall"}, {26'd0, pi1, pe1, rw1, mw1, d1, t1}, {26'd0, 6'b011100});
            check({e.tag, ".nostall_cnt"}, {16'd0, c1}, {16'd0, e.c});
         end
      end
   end
   initial begin
      step("rst0", 1, 0, 0, 0, 6'b000000, 16'd0, 0);
      step("rst1", 1, 0, 0, 0, 6'b000000, 16'd0, 0);
      step("idle", 0, 1, 0, 0, 6'b000000, 16'd0, 0);
      step("arm1", 0, 1, 0, 0, 6'b100000, 16'd0, 0);
      step("arm2", 0, 1, 0, 0, 6'b100000, 16'd0, 0);
      step("arm3", 0, 0, 0, 0, 6'b100000, 16'd0, 0);
      for (int i = 0; i < 5; i++) step("run", 0, 0, 0, 0, 6'b011100, 16'(i), 0);
      step("ack", 0, 0, 1, 0, 6'b000000, 16'd5, 0);
      step("halt1", 0, 0, 0, 0, 6'b000010, 16'd6, 0);
      step("halt2", 0, 0, 0, 0, 6'b000010, 16'd6, 0);
      step("restart", 0, 1, 0, 0, 6'b000010, 16'd6, 0);
      step("arm", 0, 0, 0, 0, 6'b100000, 16'd0, 0);
      step("run0", 0, 0, 0, 0, 6'b011100, 16'd0, 0);
      step("ld0", 0, 0, 0, 1, 6'b000000, 16'd1, 1);
      step("ld1", 0, 0, 0, 1, 6'b000000, 16'd2, 1);
      step("ld2", 0, 0, 0, 1, 6'b011000, 16'd3, 1);
      for (int i = 4; i < 7; i++) step("wdrun", 0, 0, 0, 0, 6'b011100, 16'(i), 0);
      step("wdfire", 0, 0, 0, 0, 6'b000000, 16'd7, 0);
      step("wdhalt1", 0, 0, 0, 0, 6'b000011, 16'd8, 0);
      step("wdhalt2", 0, 0, 0, 0, 6'b000011, 16'd8, 0);
      step("rearm", 0, 1, 0, 0, 6'b000011, 16'd8, 0);
      step("arm_clr", 0, 0, 0, 0, 6'b100000, 16'd0, 0);
      step("ldrun", 0, 0, 0, 1, 6'b000000, 16'd0, 0);
      step("ldabort", 0, 1, 0, 1, 6'b000000, 16'd1, 0);
      step("abort_arm", 0, 0, 0, 0, 6'b100000, 16'd0, 0);
      step("run_a", 0, 0, 0, 0, 6'b011100, 16'd0, 0);
      step("run_b", 0, 0, 0, 0, 6'b011100, 16'd1, 0);
      step("rst_mid", 1, 0, 0, 0, 6'b011100, 16'd2, 0);
      step("post_rst", 0, 0, 0, 0, 6'b000000, 16'd0, 0);
      step("idle_hold", 0, 0, 0, 0, 6'b000000, 16'd0, 0);
      @(posedge clk);
      @(posedge clk);
      check("drain", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Multi-cycle run controller for the 9-bit single-issue core.
- Sequences program start, PC advance, load-latency stalls, halt on Ack and a watchdog timeout.
- Sits beside the combinational instruction decoder; consumes its LoadInst/Ack outputs.
- Qualifies PC enable and the register/memory write enables that reach the program counter, register file and data memory.

Parameters:
- LOAD_LAT, 1: extra stall cycles for a data-memory read. 0 = no stall. Legal range 0..7.
- CNT_W, 16: width of the cycle counter.
- MAX_CYCLES, 16'hFFFF: watchdog limit on run cycles. 0 disables the watchdog.

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  testbench/host start level
- Ack  input  1  decoder: current instruction is the halt word (all ones)
- LoadInst  input  1  decoder: current instruction is a load
- PCInit  output  1  load PC with program start address
- PCEn  output  1  advance PC (normal increment or branch target)
- RegWrGate  output  1  ANDed with decoder RegWrEn
- MemWrGate  output  1  ANDed with decoder MemWrEn
- Done  output  1  program finished (Ack or timeout)
- Timeout  output  1  halt was caused by the watchdog
- CycleCount  output  CNT_W  run cycles of the current or last program

Behaviour:
- Clock and reset
  - One clock, Clk.
  - Reset is synchronous and active-high. Reset=1 at a rising edge forces IDLE regardless of state, including mid-stall.
  - Reset values: PCInit=0, PCEn=0, RegWrGate=0, MemWrGate=0, Done=0, Timeout=0, CycleCount=0, stall counter=0.
- Outputs are Moore outputs from registered state, except where noted for RUN.
- States: IDLE, ARMED, RUN, LOAD_WAIT, HALT.
- IDLE
  - All outputs 0.
  - Start=1 -> ARMED.
- ARMED
  - PCInit=1, all other strobes 0.
  - CycleCount cleared to 0; Done and Timeout cleared.
  - Stays while Start=1. Start=0 -> RUN, so the first instruction executes the cycle after Start falls.
- RUN
  - Default: PCEn=1, RegWrGate=1, MemWrGate=1, CycleCount+1.
  - Priority, highest first: Start=1, then Ack, then watchdog, then LoadInst.
  - Start=1: abort. All strobes 0 this cycle; next state ARMED.
  - Ack=1: PCEn=0, RegWrGate=0, MemWrGate=0; next state HALT. CycleCount still counts this cycle.
  - Watchdog: MAX_CYCLES!=0 and CycleCount==MAX_CYCLES-1 at the edge. Strobes 0; next state HALT with Timeout=1.
  - LoadInst=1 and LOAD_LAT>0: PCEn=0, RegWrGate=0, MemWrGate=0; stall counter<=LOAD_LAT; next state LOAD_WAIT.
  - LoadInst=1 and LOAD_LAT=0: treated as an ordinary instruction.
  - Gating in RUN depends combinationally on Ack, LoadInst and Start.
- LOAD_WAIT
  - PC is held, so the decoder inputs stay stable.
  - CycleCount increments each cycle; stall counter decrements.
  - Stall counter==1: PCEn=1, RegWrGate=1 (load writeback), MemWrGate=0; next state RUN.
  - Otherwise all strobes 0.
  - A load therefore takes LOAD_LAT+1 cycles total.
  - Start=1 aborts to ARMED, strobes 0. Watchdog is also checked here.
- HALT
  - Done=1 held, Timeout held, CycleCount frozen, all strobes 0.
  - Start=1 -> ARMED, which clears Done and Timeout.
- CycleCount
  - Saturates at all-ones; never wraps.
  - Cleared only by Reset or ARMED.
- Invariant: at most one of PCInit and PCEn is high in any cycle.

Test Plan:
- Reset then Start high 3 cycles, then low. PCInit=1 for exactly 3 cycles; PCEn=1 from the first cycle after Start falls; all outputs 0 during reset.
- Run 5 non-load instructions, then Ack=1. PCEn high 5 cycles, low on the Ack cycle. Done=1 next cycle and held; CycleCount=6; Timeout=0.
- LOAD_LAT=2, LoadInst=1 in RUN. PCEn pattern 0,0,1 over three cycles; RegWrGate 0,0,1; MemWrGate 0,0,0. Return to RUN; CycleCount advances by 3.
- LOAD_LAT=0, LoadInst=1. No stall: PCEn and RegWrGate stay 1.
- MAX_CYCLES=8, Ack never asserted. HALT after 8 run cycles with Done=1, Timeout=1, CycleCount=8.
- Mid-program resets and restarts:
  - Start=1 during LOAD_WAIT -> ARMED next cycle; PCInit=1, CycleCount=0, no RegWrGate pulse.
  - Reset=1 during RUN -> IDLE, all outputs 0 on the next edge.
